axil_req_arbiter: RTL and testbench

AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

---
 rtl/axil_req_arbiter_pkg.sv | 17 +
 rtl/axil_req_arbiter_rr_pick.sv | 33 +++
 rtl/axil_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_axil_req_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_req_arbiter_pkg.sv
// Shared definitions for the AXI-Lite request arbiter: FSM encoding,
// watchdog limit and AXI response codes.
package axil_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_CYC = 1024;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at last+1, searching
// upward with wrap-around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int               sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    sum   = 0;
    cand  = '0;
    // k = NUM_REQ revisits last_i itself, so a lone requester can win again.
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last_i) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ simple requesters onto one AXI-Lite
// master user port, with exactly one transaction outstanding at a time.
module axil_req_arbiter
  import axil_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic                           m_wr_req,
  output logic [ADDR_WIDTH-1:0]          m_wr_addr,
  output logic [DATA_WIDTH-1:0]          m_wr_data,
  output logic [DATA_WIDTH/8-1:0]        m_wr_strb,
  input  logic                           m_wr_done,
  input  logic [1:0]                     m_wr_resp,
  output logic                           m_rd_req,
  output logic [ADDR_WIDTH-1:0]          m_rd_addr,
  input  logic                           m_rd_done,
  input  logic [1:0]                     m_rd_resp,
  input  logic [DATA_WIDTH-1:0]          m_rd_data,
  output state_e                         dbg_state
);

  // Handshake: a requester holds req_valid with stable payload until it sees
  // its one-cycle req_ready pulse and drops req_valid in the following cycle;
  // rsp_valid is a one-cycle pulse with no back-pressure.

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, last_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [1:0]              rsp_resp_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    done_hit;
  logic                    time_out;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Only the done of the latched direction counts; the other one is ignored.
  assign done_hit = (state_q == ST_WAIT) && (wr_q ? m_wr_done : m_rd_done);
  assign time_out = (state_q == ST_WAIT) && !done_hit &&
                    (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            wr_q    <= req_write[pick_idx];
            addr_q  <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            wstrb_q <= req_wstrb[int'(pick_idx)*STRB_W +: STRB_W];
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          if (done_hit || time_out) begin
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            rsp_resp_q  <= time_out ? RESP_SLVERR : (wr_q ? m_wr_resp : m_rd_resp);
            rsp_rdata_q <= (wr_q || time_out) ? '0 : m_rd_data;
            last_q      <= grant_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (done_hit || time_out) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    m_wr_req  = 1'b0;
    m_rd_req  = 1'b0;
    if (state_q == ST_GRANT) req_ready = NUM_REQ'(1) << grant_q;
    if (state_q == ST_ISSUE) begin
      m_wr_req = wr_q;
      m_rd_req = !wr_q;
    end
  end

  assign m_wr_addr = addr_q;
  assign m_rd_addr = addr_q;
  assign m_wr_data = wdata_q;
  assign m_wr_strb = wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter: single write, contention, read,
// wrong-direction done, watchdog timeout and reset mid-transaction.
module tb_axil_req_arbiter;
  import axil_req_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              aclk;
  logic              aresetn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*SW-1:0]   req_wstrb;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              m_wr_req;
  logic [AW-1:0]     m_wr_addr;
  logic [DW-1:0]     m_wr_data;
  logic [SW-1:0]     m_wr_strb;
  logic              m_wr_done;
  logic [1:0]        m_wr_resp;
  logic              m_rd_req;
  logic [AW-1:0]     m_rd_addr;
  logic              m_rd_done;
  logic [1:0]        m_rd_resp;
  logic [DW-1:0]     m_rd_data;
  state_e            dbg_state;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  axil_req_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .m_wr_req  (m_wr_req),
    .m_wr_addr (m_wr_addr),
    .m_wr_data (m_wr_data),
    .m_wr_strb (m_wr_strb),
    .m_wr_done (m_wr_done),
    .m_wr_resp (m_wr_resp),
    .m_rd_req  (m_rd_req),
    .m_rd_addr (m_rd_addr),
    .m_rd_done (m_rd_done),
    .m_rd_resp (m_rd_resp),
    .m_rd_data (m_rd_data),
    .dbg_state (dbg_state)
  );

  // Clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*SW +: SW] = s;
  endtask

  initial begin
    int g;
    aresetn   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    m_wr_done = 1'b0;
    m_wr_resp = 2'b00;
    m_rd_done = 1'b0;
    m_rd_resp = 2'b00;
    m_rd_data = '0;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_m_req", {m_wr_req, m_rd_req}, 0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    aresetn = 1'b1;

    // Contention: all four valid and held, expected grant order 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(32'h100 * (i + 1)), '0, '0);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_valid = '1;
    while (exp_q.size() > 0) begin
      g = int'(exp_q.pop_front());
      tick();
      chk("cont_ready", req_ready, 64'(4'b0001 << g));
      tick();
      chk("cont_rd_req", {m_wr_req, m_rd_req}, 2'b01);
      chk("cont_rd_addr", m_rd_addr, 32'h100 * (g + 1));
      tick();
      chk("cont_busy_ready", req_ready, 0);
      tick();
      chk("cont_busy_state", 64'(dbg_state), 64'(ST_WAIT));
      m_rd_data = 32'h1000 + g;
      m_rd_done = 1'b1;
      tick();
      m_rd_done = 1'b0;
      chk("cont_rsp_valid", rsp_valid, 64'(4'b0001 << g));
      chk("cont_rdata", rsp_rdata, 32'h1000 + g);
    end
    req_valid = '0;
    tick();
    chk("cont_idle", 64'(dbg_state), 64'(ST_IDLE));

    // Single write from requester 2; payload changes after GRANT are ignored.
    set_req(2, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF);
    req_valid = 4'b0100;
    tick();
    chk("wr_ready", req_ready, 4'b0100);
    req_valid = '0;
    set_req(2, 1'b0, 32'hFFFF, 32'h0, 4'h0);
    tick();
    chk("wr_ready_drop", req_ready, 0);
    chk("wr_m_req", {m_wr_req, m_rd_req}, 2'b10);
    chk("wr_addr", m_wr_addr, 32'h10);
    chk("wr_data", m_wr_data, 32'hA5A5_A5A5);
    chk("wr_strb", m_wr_strb, 4'hF);
    tick();
    chk("wr_req_pulse", m_wr_req, 0);
    chk("wr_addr_hold", m_wr_addr, 32'h10);
    m_wr_done = 1'b1;
    m_wr_resp = 2'b00;
    tick();
    m_wr_done = 1'b0;
    chk("wr_rsp_valid", rsp_valid, 4'b0100);
    chk("wr_rsp_resp", rsp_resp, 2'b00);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    tick();
    chk("wr_rsp_pulse", rsp_valid, 0);

    // Read from requester 1.
    set_req(1, 1'b0, 32'h20, '0, '0);
    req_valid = 4'b0010;
    tick();
    chk("rd_ready", req_ready, 4'b0010);
    req_valid = '0;
    tick();
    chk("rd_m_req", {m_wr_req, m_rd_req}, 2'b01);
    chk("rd_addr", m_rd_addr, 32'h20);
    tick();
    m_rd_data = 32'hDEAD_BEEF;
    m_rd_resp = 2'b00;
    m_rd_done = 1'b1;
    tick();
    m_rd_done = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 4'b0010);
    chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_resp", rsp_resp, 2'b00);

    // Write from requester 3 with a stray read done while in flight.
    set_req(3, 1'b1, 32'h30, 32'h1234_0003, 4'h3);
    req_valid = 4'b1000;
    tick();
    chk("wd_ready", req_ready, 4'b1000);
    req_valid = '0;
    tick();
    chk("wd_m_req", {m_wr_req, m_rd_req}, 2'b10);
    tick();
    m_rd_done = 1'b1;
    m_rd_resp = 2'b10;
    tick();
    m_rd_done = 1'b0;
    m_rd_resp = 2'b00;
    chk("wd_stray_rsp", rsp_valid, 0);
    chk("wd_stray_state", 64'(dbg_state), 64'(ST_WAIT));
    tick();
    m_wr_done = 1'b1;
    tick();
    m_wr_done = 1'b0;
    chk("wd_rsp_valid", rsp_valid, 4'b1000);
    chk("wd_rsp_resp", rsp_resp, 2'b00);

    // Timeout on requester 0 while requester 1 waits its turn.
    set_req(0, 1'b1, 32'h40, 32'h0000_0040, 4'h1);
    set_req(1, 1'b0, 32'h50, '0, '0);
    req_valid = 4'b0001;
    tick();
    chk("to_ready", req_ready, 4'b0001);
    req_valid = 4'b0010;
    tick();
    chk("to_m_req", {m_wr_req, m_rd_req}, 2'b10);
    tick();
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
    chk("to_still_wait", 64'(dbg_state), 64'(ST_WAIT));
    chk("to_no_rsp_yet", rsp_valid, 0);
    tick();
    chk("to_rsp_valid", rsp_valid, 4'b0001);
    chk("to_rsp_resp", rsp_resp, 2'b10);
    m_wr_done = 1'b1;
    tick();
    m_wr_done = 1'b0;
    req_valid = '0;
    chk("to_next_ready", req_ready, 4'b0010);
    chk("to_stale_rsp", rsp_valid, 0);
    tick();
    chk("to_next_rd_req", {m_wr_req, m_rd_req}, 2'b01);
    chk("to_next_addr", m_rd_addr, 32'h50);
    tick();
    m_rd_data = 32'h1234_5678;
    m_rd_done = 1'b1;
    tick();
    m_rd_done = 1'b0;
    chk("to_next_rsp", rsp_valid, 4'b0010);
    chk("to_next_rdata", rsp_rdata, 32'h1234_5678);

    // Reset during WAIT drops the transaction.
    set_req(2, 1'b1, 32'h60, 32'h0000_0055, 4'hF);
    req_valid = 4'b0100;
    tick();
    chk("rw_ready", req_ready, 4'b0100);
    req_valid = '0;
    tick();
    tick();
    chk("rw_in_wait", 64'(dbg_state), 64'(ST_WAIT));
    aresetn = 1'b0;
    #1;
    chk("rw_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rw_outs", {req_ready, rsp_valid, m_wr_req, m_rd_req, rsp_resp}, 0);
    chk("rw_addr", m_wr_addr, 0);
    chk("rw_data", m_wr_data, 0);
    chk("rw_rdata", rsp_rdata, 0);
    m_wr_done = 1'b1;
    tick();
    m_wr_done = 1'b0;
    chk("rw_no_rsp", rsp_valid, 0);
    aresetn = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(32'h700 + i), '0, '0);
    req_valid = '1;
    tick();
    chk("rw_first_ready", req_ready, 4'b0001);
    chk("rw_no_rsp_after", rsp_valid, 0);
    req_valid = '0;
    tick();
    chk("rw_first_addr", m_rd_addr, 32'h700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
